// File: rtl/gate_scheduler.sv
// ============================================================================
// Module   : gate_scheduler
// Brief    : Single-gate parking lot arbiter with occupancy count and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_scheduler #(
  parameter int CAPACITY = 10,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entryReq,
  input  logic       exitReq,
  input  logic       passDone,
  input  logic       gateFault,
  output logic       entryGrant,
  output logic       exitGrant,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       timeoutAlarm
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_BUSY = 2'd1,
    EXIT_BUSY  = 2'd2,
    FAULT      = 2'd3
  } state_t;

  localparam logic [3:0] C_CAP      = 4'(CAPACITY);
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_timer;
  logic [7:0] w_next_timer;
  logic [3:0] r_occ;
  logic [3:0] w_next_occ;
  logic       r_last_entry;
  logic       w_next_last_entry;
  logic       r_alarm;
  logic       w_next_alarm;
  logic       r_entry_grant;
  logic       r_exit_grant;

  logic       w_full;
  logic       w_entry_ok;
  logic       w_exit_ok;
  logic       w_serving_entry;

  assign w_full          = (r_occ == C_CAP);
  assign w_entry_ok      = entryReq && !w_full;
  assign w_exit_ok       = exitReq && (r_occ != 4'd0);
  assign w_serving_entry = (r_state == ENTRY_BUSY);

  always_comb begin
    w_next_state      = r_state;
    w_next_timer      = r_timer;
    w_next_occ        = r_occ;
    w_next_last_entry = r_last_entry;
    w_next_alarm      = 1'b0;

    // A fault pre-empts completion, timeout and new grants alike.
    if (gateFault && (r_state != FAULT)) begin
      w_next_state = FAULT;
      w_next_timer = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_timer = 8'd0;
          if (w_entry_ok && w_exit_ok) begin
            w_next_state = r_last_entry ? EXIT_BUSY : ENTRY_BUSY;
          end else if (w_entry_ok) begin
            w_next_state = ENTRY_BUSY;
          end else if (w_exit_ok) begin
            w_next_state = EXIT_BUSY;
          end
        end
        ENTRY_BUSY, EXIT_BUSY: begin
          if (passDone) begin
            w_next_state      = IDLE;
            w_next_timer      = 8'd0;
            w_next_last_entry = w_serving_entry;
            if (w_serving_entry && (r_occ < C_CAP)) begin
              w_next_occ = r_occ + 4'd1;
            end else if (!w_serving_entry && (r_occ != 4'd0)) begin
              w_next_occ = r_occ - 4'd1;
            end
          end else if (r_timer == C_TMO_LAST) begin
            w_next_state      = IDLE;
            w_next_timer      = 8'd0;
            w_next_alarm      = 1'b1;
            w_next_last_entry = w_serving_entry;
          end else begin
            w_next_timer = r_timer + 8'd1;
          end
        end
        FAULT: begin
          w_next_timer = 8'd0;
          if (!gateFault) begin
            w_next_state = IDLE;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_timer = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timer       <= 8'd0;
      r_occ         <= 4'd0;
      r_last_entry  <= 1'b0;
      r_alarm       <= 1'b0;
      r_entry_grant <= 1'b0;
      r_exit_grant  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_next_timer;
      r_occ         <= w_next_occ;
      r_last_entry  <= w_next_last_entry;
      r_alarm       <= w_next_alarm;
      r_entry_grant <= (w_next_state == ENTRY_BUSY);
      r_exit_grant  <= (w_next_state == EXIT_BUSY);
    end
  end

  assign entryGrant   = r_entry_grant;
  assign exitGrant    = r_exit_grant;
  assign occupancy    = r_occ;
  assign full         = w_full;
  assign timeoutAlarm = r_alarm;

endmodule

`default_nettype wire
